// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: IF/ID register, load-use stall and redirect squash control with perf counters
module id_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [2:0]       id_imm_sel,
  output logic             stall_if,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, state_nx;
  logic [2:0] sq_cnt;
  logic [2:0] imm_sel_nx;
  logic [6:0] op;
  logic r_type, uses_rs1, uses_rs2, hazard;
  // pre-decode the immediate format of the incoming instruction
  always_comb begin
    op = if_inst[6:0];
    imm_sel_nx = (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111) ? 3'd1 :
                 (op == 7'b0100011) ? 3'd2 :
                 (op == 7'b1100011) ? 3'd3 :
                 (op == 7'b0110111 || op == 7'b0010111) ? 3'd4 :
                 (op == 7'b1101111) ? 3'd5 : 3'd0;
  end
  // load-use detection against the load sitting in EX
  always_comb begin
    r_type = id_inst[6:0] == 7'b0110011;
    uses_rs1 = r_type | id_imm_sel == 3'd1 | id_imm_sel == 3'd2 | id_imm_sel == 3'd3;
    uses_rs2 = r_type | id_imm_sel == 3'd2 | id_imm_sel == 3'd3;
    hazard = id_valid & ex_mem_read & (ex_rd != 5'd0) &
             ((uses_rs1 & id_inst[19:15] == ex_rd) | (uses_rs2 & id_inst[24:20] == ex_rd));
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state_nx;
  end
  // next state: a redirect (re)enters the squash window, which ends when the counter runs out
  always_comb begin
    state_nx = ex_redirect ? (FLUSH_DEPTH > 1 ? SQUASH : RUN) :
               (state == SQUASH && sq_cnt <= 3'd1) ? RUN : state;
  end
  // stall and bubble controls; a redirect overrides the stall
  always_comb begin
    stall_if = hazard & ~ex_redirect;
    ex_valid = id_valid & ~hazard & ~ex_redirect & (state != SQUASH);
  end
  // IF/ID register: flush beats stall beats capture
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst <= 32'h0000_0013;
      id_pc <= 32'd0;
      id_imm_sel <= 3'd0;
    end else if (ex_redirect || state == SQUASH) begin
      id_valid <= 1'b0;
    end else if (!hazard) begin
      id_valid <= if_valid;
      id_inst <= if_inst;
      id_pc <= if_pc;
      id_imm_sel <= imm_sel_nx;
    end
  end
  // squash window counter and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_cnt <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sq_cnt <= ex_redirect ? 3'(FLUSH_DEPTH - 1) : (state == SQUASH && sq_cnt != 3'd0) ? sq_cnt - 3'd1 : sq_cnt;
      if (stall_if) stall_cnt <= stall_cnt + CNT_W'(stall_cnt != '1);
      if (ex_redirect) flush_cnt <= flush_cnt + CNT_W'(flush_cnt != '1);
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: table-driven scoreboard bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013, ADDI = 32'h0011_8293, LUI = 32'h1234_51B7,
    SW = 32'h0031_2023, ADD = 32'h0031_00B3, BEQ = 32'h0000_0063, LW = 32'h0002_A083,
    JAL = 32'h0000_006F, AUIPC = 32'h0000_0097, JALR = 32'h0000_80E7, UNK = 32'h0000_000B;
  typedef struct {
    int rst, iv;
    logic [31:0] inst, pc;
    int mr, rd, rdr;
    int st, ev, idv;
    logic [31:0] xi, xp;
    int xs, sc, fc;
  } vec_t;
  logic clk, rst, if_valid, ex_mem_read, ex_redirect;
  logic [31:0] if_inst, if_pc;
  logic [4:0] ex_rd;
  logic id_valid, stall_if, ex_valid;
  logic [31:0] id_inst, id_pc;
  logic [2:0] id_imm_sel;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  vec_t q[$];
  vec_t tv[28];
  id_hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_imm_sel(id_imm_sel),
    .stall_if(stall_if), .ex_valid(ex_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int idx, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", n, idx, a, e);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic st_s, ev_s;
    @(negedge clk);
    rst = v.rst[0];
    if_valid = v.iv[0];
    if_inst = v.inst;
    if_pc = v.pc;
    ex_mem_read = v.mr[0];
    ex_rd = v.rd[4:0];
    ex_redirect = v.rdr[0];
    q.push_back(v);
    #1;
    st_s = stall_if;
    ev_s = ex_valid;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("stall_if", idx, 32'(st_s), e.st);
    chk("ex_valid", idx, 32'(ev_s), e.ev);
    chk("id_valid", idx, 32'(id_valid), e.idv);
    chk("id_inst", idx, id_inst, e.xi);
    chk("id_pc", idx, id_pc, e.xp);
    chk("id_imm_sel", idx, 32'(id_imm_sel), e.xs);
    chk("stall_cnt", idx, 32'(stall_cnt), e.sc);
    chk("flush_cnt", idx, 32'(flush_cnt), e.fc);
  endtask
  initial begin
    vec_t v;
    tv[0]  = '{1, 1, ADDI, 'h100, 1, 3, 1, 0, 0, 0, NOP, 0, 0, 0, 0};
    tv[1]  = '{0, 1, ADDI, 'h100, 0, 0, 0, 0, 0, 1, ADDI, 'h100, 1, 0, 0};
    tv[2]  = '{0, 1, LUI, 'h104, 1, 3, 0, 1, 0, 1, ADDI, 'h100, 1, 1, 0};
    tv[3]  = '{0, 1, LUI, 'h104, 0, 0, 0, 0, 1, 1, LUI, 'h104, 4, 1, 0};
    tv[4]  = '{0, 1, LUI, 'h108, 1, 0, 0, 0, 1, 1, LUI, 'h108, 4, 1, 0};
    tv[5]  = '{0, 1, SW, 'h10C, 1, 3, 0, 0, 1, 1, SW, 'h10C, 2, 1, 0};
    tv[6]  = '{0, 1, ADD, 'h110, 1, 3, 0, 1, 0, 1, SW, 'h10C, 2, 2, 0};
    tv[7]  = '{0, 1, ADD, 'h110, 1, 2, 0, 1, 0, 1, SW, 'h10C, 2, 3, 0};
    tv[8]  = '{0, 1, ADD, 'h110, 0, 0, 0, 0, 1, 1, ADD, 'h110, 0, 3, 0};
    tv[9]  = '{0, 1, BEQ, 'h114, 1, 3, 0, 1, 0, 1, ADD, 'h110, 0, 4, 0};
    tv[10] = '{0, 1, BEQ, 'h114, 1, 1, 0, 0, 1, 1, BEQ, 'h114, 3, 4, 0};
    tv[11] = '{0, 1, LW, 'h118, 0, 0, 0, 0, 1, 1, LW, 'h118, 1, 4, 0};
    tv[12] = '{0, 1, JAL, 'h11C, 1, 5, 1, 0, 0, 0, LW, 'h118, 1, 4, 1};
    tv[13] = '{0, 1, JAL, 'h11C, 0, 0, 0, 0, 0, 0, LW, 'h118, 1, 4, 1};
    tv[14] = '{0, 1, JAL, 'h120, 0, 0, 0, 0, 0, 1, JAL, 'h120, 5, 4, 1};
    tv[15] = '{0, 1, AUIPC, 'h124, 0, 0, 1, 0, 0, 0, JAL, 'h120, 5, 4, 2};
    tv[16] = '{0, 1, JALR, 'h128, 0, 0, 0, 0, 0, 0, JAL, 'h120, 5, 4, 2};
    tv[17] = '{0, 1, UNK, 'h12C, 0, 0, 0, 0, 0, 1, UNK, 'h12C, 0, 4, 2};
    tv[18] = '{0, 1, JALR, 'h130, 0, 0, 1, 0, 0, 0, UNK, 'h12C, 0, 4, 3};
    tv[19] = '{0, 1, JALR, 'h134, 0, 0, 1, 0, 0, 0, UNK, 'h12C, 0, 4, 4};
    tv[20] = '{0, 1, JALR, 'h138, 0, 0, 0, 0, 0, 0, UNK, 'h12C, 0, 4, 4};
    tv[21] = '{0, 1, JALR, 'h13C, 0, 0, 0, 0, 0, 1, JALR, 'h13C, 1, 4, 4};
    tv[22] = '{0, 0, ADDI, 'h140, 0, 0, 0, 0, 1, 0, ADDI, 'h140, 1, 4, 4};
    tv[23] = '{0, 1, NOP, 'h144, 0, 0, 1, 0, 0, 0, ADDI, 'h140, 1, 4, 5};
    tv[24] = '{1, 1, ADDI, 'h148, 1, 3, 0, 0, 0, 0, NOP, 0, 0, 0, 0};
    tv[25] = '{0, 1, ADDI, 'h14C, 0, 0, 0, 0, 0, 1, ADDI, 'h14C, 1, 0, 0};
    tv[26] = '{0, 1, LUI, 'h150, 1, 3, 0, 1, 0, 1, ADDI, 'h14C, 1, 1, 0};
    tv[27] = '{1, 1, LUI, 'h154, 1, 3, 0, 1, 0, 0, NOP, 0, 0, 0, 0};
    rst = 1'b1;
    if_valid = 1'b0;
    if_inst = 32'hDEAD_BEEF;
    if_pc = 32'h0;
    ex_mem_read = 1'b1;
    ex_rd = 5'd7;
    ex_redirect = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 28; i++) apply(tv[i], i);
    apply('{0, 1, ADDI, 'h200, 0, 0, 0, 0, 0, 1, ADDI, 'h200, 1, 0, 0}, 100);
    for (int i = 0; i < 20; i++) begin
      v = '{0, 1, LUI, 'h204, 1, 3, 0, 1, 0, 1, ADDI, 'h200, 1, (i + 1 > 15) ? 15 : i + 1, 0};
      apply(v, 101 + i);
    end
    apply('{1, 0, LUI, 'h208, 1, 3, 0, 1, 0, 0, NOP, 0, 0, 0, 0}, 130);
    for (int i = 0; i < 20; i++) begin
      v = '{0, 1, LUI, 'h20C, 0, 0, 1, 0, 0, 0, NOP, 0, 0, 0, (i + 1 > 15) ? 15 : i + 1};
      apply(v, 131 + i);
    end
    apply('{1, 0, LUI, 'h210, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0}, 160);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
